// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-bounded sharing of one FIFO write port
// among NUM_REQ producers in the FIFO write clock domain.
module fifo_write_arbiter #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BITS-1:0]    req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       p_write_en,
  output logic [BITS-1:0]            p_write_data,
  input  logic                       p_write_full,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                write_count
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  // One extra value keeps the counter at least 1 bit wide when MAX_BURST=1.
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   owner;
  logic [CNT_W-1:0]  burst_cnt;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   scan_id;
  logic              owner_valid;
  logic              xfer;

  // Circular search for the first valid producer starting at rr_ptr.
  // The wrap compares against LAST_ID so non-power-of-two NUM_REQ works.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = rr_ptr;
    scan_id    = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
      scan_id = (scan_id == LAST_ID) ? '0 : scan_id + ID_W'(1);
    end
  end

  // Port steering from the current owner; reset masks every handshake.
  always_comb begin
    owner_valid  = req_valid[owner];
    xfer         = (state == BURST) && owner_valid && !p_write_full && !rst;
    req_ready    = '0;
    if ((state == BURST) && !p_write_full && !rst) begin
      req_ready[owner] = 1'b1;
    end
    p_write_en   = xfer;
    p_write_data = req_data[32'(owner) * BITS +: BITS];
    grant_valid  = (state == BURST);
    grant_id     = owner;
  end

  // Arbitration FSM, burst accounting and accepted-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      burst_cnt   <= '0;
      write_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner     <= pick_id;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            write_count <= write_count + 16'd1;
            burst_cnt   <= burst_cnt + CNT_W'(1);
          end
          // A full stall alone keeps the grant; only a finished burst or a
          // dropped valid hands the port on.
          if ((xfer && (burst_cnt == LAST_CNT)) || !owner_valid) begin
            state  <= IDLE;
            rr_ptr <= (owner == LAST_ID) ? '0 : owner + ID_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: producer queues, a transaction-level
// arbitration model and directed plus randomized scenarios.
module tb_fifo_write_arbiter;

  localparam int unsigned BITS      = 32;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAX_BURST = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*BITS-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    p_write_en;
  logic [BITS-1:0]         p_write_data;
  logic                    p_write_full;
  logic                    grant_valid;
  logic [1:0]              grant_id;
  logic [15:0]             write_count;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.BITS(BITS), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .p_write_en(p_write_en), .p_write_data(p_write_data),
    .p_write_full(p_write_full), .grant_valid(grant_valid), .grant_id(grant_id),
    .write_count(write_count)
  );

  // Producer word queues and the knobs each test sets before a cycle.
  logic [BITS-1:0]    q [NUM_REQ][$];
  logic               rst_set;
  logic               full_set;
  logic [NUM_REQ-1:0] want;

  // Model: which producer holds the port, words granted so far, next start.
  bit     m_busy;
  int     m_owner, m_cnt, m_ptr, m_wc;
  logic [NUM_REQ-1:0] e_ready;
  logic               e_wen;
  logic [BITS-1:0]    e_data;
  logic [55:0]        obs_v, exp_v;
  int checks = 0, failures = 0, cyc = 0;

  // One clock: advance the model on the edge, drive new inputs, then form
  // observed and expected output vectors on the falling edge.
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    bit xfer, found;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_wc = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin found = 1; m_owner = idx; end
      end
      if (found) begin m_cnt = 0; m_busy = 1; end
    end else begin
      xfer = req_valid[m_owner] && !p_write_full;
      if (xfer) begin m_wc = (m_wc + 1) % 65536; m_cnt++; end
      if ((xfer && m_cnt == MAX_BURST) || !req_valid[m_owner]) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NUM_REQ;
      end
    end
    acc = req_valid & e_ready;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
    #1;
    rst = rst_set;
    p_write_full = full_set;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!(req_valid[i] && !acc[i] && q[i].size() > 0)) begin
        req_valid[i] = want[i] && (q[i].size() > 0);
        req_data[i*BITS +: BITS] = req_valid[i] ? q[i][0] : BITS'($urandom);
      end
    end
    @(negedge clk);
    e_ready = (!rst && m_busy && !p_write_full) ? NUM_REQ'(1 << m_owner) : '0;
    e_wen   = !rst && m_busy && req_valid[m_owner] && !p_write_full;
    e_data  = e_wen ? q[m_owner][0] : '0;
    obs_v = {req_ready, p_write_en, grant_valid, grant_valid ? grant_id : 2'd0,
             write_count, p_write_en ? p_write_data : 32'd0};
    exp_v = {e_ready, e_wen, m_busy, m_busy ? 2'(m_owner) : 2'd0,
             16'(m_wc), e_data};
  endtask

  task automatic reset_all();
    rst_set = 1; want = '0; full_set = 0;
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    tick(); tick();
    rst_set = 0;
  endtask

  task automatic test_reset();
    int t = 0;
    rst_set = 1; full_set = 0; want = '1;
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 4; k++) q[i].push_back(BITS'((i << 8) | k));
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({req_ready, p_write_en, grant_valid, write_count} !== 22'd0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=0", cyc,
                 {req_ready, p_write_en, grant_valid, write_count});
      end
    end
    rst_set = 0;
    while (!grant_valid && t < 6) begin
      tick(); t++;
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (!grant_valid || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_grant got_valid=%0b got_id=%0d exp_id=0", grant_valid, grant_id);
    end
  endtask

  task automatic test_single();
    int nw = 0, run = 0, gap = 0, t = 0;
    int runs[$];
    int gaps[$];
    int exp_runs[3] = '{4, 4, 2};
    reset_all();
    for (int k = 0; k < 10; k++) q[2].push_back(BITS'(32'h100 + k));
    want = 4'b0100;
    while (t < 60 && !(nw == 10 && !grant_valid)) begin
      tick(); t++;
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (p_write_en) begin
        if (run == 0 && nw > 0) gaps.push_back(gap);
        checks++;
        if (p_write_data !== BITS'(32'h100 + nw)) begin
          failures++; $display("FAIL single_data got=%h exp=%h", p_write_data, 32'h100 + nw);
        end
        run++; nw++;
      end else begin
        if (run > 0) begin runs.push_back(run); gap = 0; end
        run = 0; gap++;
      end
    end
    checks++;
    if (t >= 60) begin failures++; $display("FAIL single_timeout got_words=%0d exp=10", nw); end
    checks++;
    if (runs.size() != 3) begin
      failures++; $display("FAIL single_nbursts got=%0d exp=3", runs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (runs[i] != exp_runs[i]) begin failures++; $display("FAIL single_burst%0d got=%0d exp=%0d", i, runs[i], exp_runs[i]); end
      end
    end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] != 1) begin failures++; $display("FAIL single_gap%0d got=%0d exp=1", i, gaps[i]); end
    end
    checks++;
    if (write_count !== 16'd10) begin failures++; $display("FAIL single_count got=%0d exp=10", write_count); end
  endtask

  task automatic test_fairness();
    int nw = 0, cur = 0;
    bit prev_gv = 0;
    int grants[$];
    int words[$];
    int exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    reset_all();
    for (int i = 0; i < NUM_REQ; i++)
      for (int k = 0; k < 8; k++) q[i].push_back(BITS'((i << 8) | k));
    want = '1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL fair_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (grant_valid && !prev_gv) begin grants.push_back(int'(grant_id)); cur = 0; end
      if (!grant_valid && prev_gv) words.push_back(cur);
      if (p_write_en) begin nw++; cur++; end
      prev_gv = grant_valid;
    end
    if (prev_gv) words.push_back(cur);
    checks++;
    if (nw != 32) begin failures++; $display("FAIL fair_words got=%0d exp=32", nw); end
    checks++;
    if (grants.size() != 8) begin
      failures++; $display("FAIL fair_ngrants got=%0d exp=8", grants.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (grants[i] != exp_g[i]) begin failures++; $display("FAIL fair_grant%0d got=%0d exp=%0d", i, grants[i], exp_g[i]); end
      end
    end
    foreach (words[i]) begin
      checks++;
      if (words[i] != 4) begin failures++; $display("FAIL fair_len%0d got=%0d exp=4", i, words[i]); end
    end
  endtask

  task automatic test_backpressure();
    int nw = 0, t = 0, ng = 0;
    bit prev_gv = 0;
    reset_all();
    for (int k = 0; k < 4; k++) q[1].push_back(BITS'(32'hB0 + k));
    want = 4'b0010;
    for (int phase = 0; phase < 3; phase++) begin
      t = 0;
      full_set = (phase == 1);
      while (t < 20 && ((phase == 0 && nw < 2) || (phase == 1 && t < 5) || (phase == 2 && t < 12))) begin
        tick(); t++;
        checks++;
        if (obs_v !== exp_v) begin failures++; $display("FAIL bp_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
        if (phase == 1) begin
          checks++;
          if (p_write_en !== 1'b0) begin failures++; $display("FAIL bp_write_while_full got=%b exp=0", p_write_en); end
        end
        if (grant_valid && !prev_gv) ng++;
        prev_gv = grant_valid;
        if (p_write_en) begin
          checks++;
          if (p_write_data !== BITS'(32'hB0 + nw)) begin failures++; $display("FAIL bp_data got=%h exp=%h", p_write_data, 32'hB0 + nw); end
          nw++;
        end
      end
    end
    checks++;
    if (nw != 4) begin failures++; $display("FAIL bp_words got=%0d exp=4", nw); end
    checks++;
    if (ng != 1) begin failures++; $display("FAIL bp_grants got=%0d exp=1", ng); end
    checks++;
    if (write_count !== 16'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", write_count); end
  endtask

  task automatic test_early_release();
    int t = 0;
    bit prev_gv = 0;
    int grants[$];
    int exp_g[3] = '{1, 3, 0};
    reset_all();
    q[0].push_back(32'hA0);
    want = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL er_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (write_count !== 16'd1 || grant_valid !== 1'b0) begin
      failures++; $display("FAIL er_setup got_count=%0d got_gv=%b exp=1,0", write_count, grant_valid);
    end
    q[1].push_back(32'hA1);
    for (int k = 0; k < 2; k++) begin q[0].push_back(BITS'(32'hC0 + k)); q[3].push_back(BITS'(32'hD0 + k)); end
    want = 4'b1011;
    while (t < 60 && !(q[0].size() + q[1].size() + q[3].size() == 0 && !m_busy)) begin
      tick(); t++;
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL er_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (grant_valid && !prev_gv) grants.push_back(int'(grant_id));
      prev_gv = grant_valid;
    end
    checks++;
    if (t >= 60) begin failures++; $display("FAIL er_timeout got_cycles=%0d exp<60", t); end
    checks++;
    if (grants.size() != 3) begin
      failures++; $display("FAIL er_ngrants got=%0d exp=3", grants.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (grants[i] != exp_g[i]) begin failures++; $display("FAIL er_grant%0d got=%0d exp=%0d", i, grants[i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int nw = 0, t = 0;
    reset_all();
    for (int k = 0; k < 8; k++) q[2].push_back(BITS'(32'hE0 + k));
    want = 4'b0100;
    while (nw < 2 && t < 20) begin
      tick(); t++;
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rmb_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
      if (p_write_en) nw++;
    end
    rst_set = 1;
    for (int k = 0; k < 2; k++) q[0].push_back(BITS'(32'hF0 + k));
    want = 4'b0101;
    tick();
    checks++;
    if (p_write_en !== 1'b0 || req_ready !== 4'd0) begin
      failures++; $display("FAIL rmb_pulse got_wen=%b got_ready=%b exp=0,0000", p_write_en, req_ready);
    end
    rst_set = 0;
    tick();
    checks++;
    if (write_count !== 16'd0 || grant_valid !== 1'b0) begin
      failures++; $display("FAIL rmb_after got_count=%0d got_gv=%b exp=0,0", write_count, grant_valid);
    end
    t = 0;
    while (!grant_valid && t < 10) begin
      tick(); t++;
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rmb_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
    checks++;
    if (!grant_valid || grant_id !== 2'd0) begin
      failures++; $display("FAIL rmb_grant got_gv=%b got_id=%0d exp_id=0", grant_valid, grant_id);
    end
  endtask

  task automatic test_random();
    reset_all();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q[i].size() == 0 && $urandom_range(7) == 0) begin
          int n;
          n = int'($urandom_range(1, 10));
          for (int k = 0; k < n; k++) q[i].push_back(BITS'($urandom));
        end
        want[i] = ($urandom_range(3) != 0);
      end
      full_set = ($urandom_range(3) == 0);
      tick();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v); end
    end
  endtask

  initial begin
    rst = 1; req_valid = '0; req_data = '0; p_write_full = 0;
    rst_set = 1; full_set = 0; want = '0;
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_wc = 0;
    e_ready = '0; e_wen = 0; e_data = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
